// File: rtl/md_scheduler_if.sv
// E-stage multiply/divide issue bundle and HI/LO result bundle.
// The master side is the pipeline and the slave side is md_scheduler.
interface md_scheduler_if;
    logic        start_E;
    logic [1:0]  md_op_E;
    logic        hilo_wr_E;
    logic        hilo_sel_E;
    logic [31:0] A_E;
    logic [31:0] B_E;
    logic        md_use_D;
    logic        stall_md;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start_E, md_op_E, hilo_wr_E, hilo_sel_E,
        output A_E, B_E, md_use_D,
        input  stall_md, busy, done, hi, lo
    );

    modport slave (
        input  start_E, md_op_E, hilo_wr_E, hilo_sel_E,
        input  A_E, B_E, md_use_D,
        output stall_md, busy, done, hi, lo
    );
endinterface

// File: rtl/md_scheduler.sv
// Fixed-latency multiply/divide scheduler that owns the HI/LO registers.
// The result is computed at issue and committed when the busy count expires.
module md_scheduler #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic           clk,
    input logic           reset,
    md_scheduler_if.slave md
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                          MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [31:0]     res_hi, res_hi_n;
    logic [31:0]     res_lo, res_lo_n;
    logic [31:0]     hi_q, hi_n;
    logic [31:0]     lo_q, lo_n;
    logic            done_q, done_n;

    logic [31:0]     a, b;
    logic signed [63:0] prod_s;
    logic [63:0]     prod_u;
    logic [31:0]     abs_a, abs_b;
    logic [31:0]     q_mag, r_mag;
    logic [31:0]     calc_hi, calc_lo;
    logic            div_zero;

    assign a = md.A_E;
    assign b = md.B_E;

    // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly.
    always_comb begin
        prod_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prod_u   = {32'd0, a} * {32'd0, b};
        abs_a    = a[31] ? (~a + 32'd1) : a;
        abs_b    = b[31] ? (~b + 32'd1) : b;
        div_zero = (b == 32'd0);
        q_mag    = div_zero ? 32'd0 : abs_a / abs_b;
        r_mag    = div_zero ? 32'd0 : abs_a % abs_b;
        calc_hi  = hi_q;
        calc_lo  = lo_q;
        unique case (md.md_op_E)
            2'b00: {calc_hi, calc_lo} = prod_s;
            2'b01: {calc_hi, calc_lo} = prod_u;
            2'b10: begin
                calc_lo = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
                calc_hi = a[31] ? (~r_mag + 32'd1) : r_mag;
            end
            2'b11: begin
                calc_lo = div_zero ? 32'd0 : a / b;
                calc_hi = div_zero ? 32'd0 : a % b;
            end
            default: ;
        endcase
        if (md.md_op_E[1] && div_zero) begin
            calc_hi = hi_q;
            calc_lo = lo_q;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        res_hi_n = res_hi;
        res_lo_n = res_lo;
        hi_n     = hi_q;
        lo_n     = lo_q;
        done_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (md.start_E) begin
                    res_hi_n = calc_hi;
                    res_lo_n = calc_lo;
                    cnt_n    = md.md_op_E[1] ? CW'(DIV_CYCLES) :
                                               CW'(MULT_CYCLES);
                    state_n  = RUN;
                end else if (md.hilo_wr_E) begin
                    if (md.hilo_sel_E) hi_n = a;
                    else               lo_n = a;
                end
            end
            RUN: begin
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    hi_n    = res_hi;
                    lo_n    = res_lo;
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            res_hi <= '0;
            res_lo <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            res_hi <= res_hi_n;
            res_lo <= res_lo_n;
            hi_q   <= hi_n;
            lo_q   <= lo_n;
            done_q <= done_n;
        end
    end

    assign md.busy     = (state == RUN);
    assign md.done     = done_q;
    assign md.hi       = hi_q;
    assign md.lo       = lo_q;
    assign md.stall_md = md.md_use_D & (md.busy | md.start_E);
endmodule

// File: tb/tb_md_scheduler.sv
// Directed bench for md_scheduler: latency, arithmetic, stall and reset.
// Inputs change on the falling edge; outputs are checked away from it.
module tb_md_scheduler;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    md_scheduler_if m ();

    md_scheduler #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .md   (m.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    always @(posedge clk) begin
        if (reset && m.busy && (m.start_E || m.hilo_wr_E)) begin
            failures++;
            $error("FAIL issue_in_run: got issue expected none");
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues at the current falling edge; returns in the done cycle.
    task automatic run_op(input logic [1:0]  op,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input int          n,
                          input logic        use_d);
        m.start_E  = 1'b1;
        m.md_op_E  = op;
        m.A_E      = a;
        m.B_E      = b;
        m.md_use_D = use_d;
        #1 chk("stall_start", 32'(m.stall_md), 32'(use_d));
        @(negedge clk);
        m.start_E = 1'b0;
        m.A_E     = '0;
        m.B_E     = '0;
        for (int i = 0; i < n; i++) begin
            #1;
            chk("busy_run", 32'(m.busy), 32'd1);
            chk("stall_run", 32'(m.stall_md), 32'(use_d));
            chk("done_run", 32'(m.done), 32'd0);
            @(negedge clk);
        end
        #1;
        chk("busy_end", 32'(m.busy), 32'd0);
        chk("done_pulse", 32'(m.done), 32'd1);
        chk("stall_end", 32'(m.stall_md), 32'd0);
        m.md_use_D = 1'b0;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b0;
        m.start_E    = 1'b0;
        m.md_op_E    = 2'b00;
        m.hilo_wr_E  = 1'b0;
        m.hilo_sel_E = 1'b0;
        m.A_E        = '0;
        m.B_E        = '0;
        m.md_use_D   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(m.busy), 32'd0);
        chk("rst_done", 32'(m.done), 32'd0);
        chk("rst_hi", m.hi, 32'd0);
        chk("rst_lo", m.lo, 32'd0);
        chk("rst_stall", 32'(m.stall_md), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        run_op(2'b00, 32'd7, 32'hFFFF_FFFD, 5, 1'b1);
        chk("mult_hi", m.hi, 32'hFFFF_FFFF);
        chk("mult_lo", m.lo, 32'hFFFF_FFEB);
        @(negedge clk);
        #1 chk("mult_done_once", 32'(m.done), 32'd0);

        @(negedge clk);
        run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 5, 1'b0);
        chk("multu_hi", m.hi, 32'h0000_0001);
        chk("multu_lo", m.lo, 32'hFFFF_FFFE);

        @(negedge clk);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 10, 1'b1);
        chk("div_hi", m.hi, 32'hFFFF_FFFF);
        chk("div_lo", m.lo, 32'hFFFF_FFFD);
        // back-to-back issue in the done cycle
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0);
        chk("divovf_hi", m.hi, 32'h0000_0000);
        chk("divovf_lo", m.lo, 32'h8000_0000);

        @(negedge clk);
        m.hilo_wr_E  = 1'b1;
        m.hilo_sel_E = 1'b1;
        m.A_E        = 32'h1234;
        @(negedge clk);
        #1 chk("mthi", m.hi, 32'h0000_1234);
        m.hilo_sel_E = 1'b0;
        m.A_E        = 32'h5678;
        @(negedge clk);
        m.hilo_wr_E = 1'b0;
        #1 chk("mtlo", m.lo, 32'h0000_5678);
        chk("mtlo_hi_kept", m.hi, 32'h0000_1234);

        @(negedge clk);
        run_op(2'b11, 32'h9999, 32'd0, 10, 1'b0);
        chk("divz_hi", m.hi, 32'h0000_1234);
        chk("divz_lo", m.lo, 32'h0000_5678);

        @(negedge clk);
        m.start_E = 1'b1;
        m.md_op_E = 2'b10;
        m.A_E     = 32'd100;
        m.B_E     = 32'd7;
        @(negedge clk);
        m.start_E = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", 32'(m.busy), 32'd0);
        chk("arst_hi", m.hi, 32'd0);
        chk("arst_lo", m.lo, 32'd0);
        chk("arst_done", 32'(m.done), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        m.hilo_wr_E  = 1'b1;
        m.hilo_sel_E = 1'b0;
        m.A_E        = 32'hABCD;
        @(negedge clk);
        m.hilo_wr_E = 1'b0;
        #1;
        chk("post_mtlo", m.lo, 32'h0000_ABCD);
        chk("post_hi", m.hi, 32'd0);
        for (int i = 0; i < 12; i++) begin
            chk("post_no_done", 32'(m.done), 32'd0);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
